control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port Clock, input, 1 bit: single system clock; all state updates occur on its rising edge.
REQ-002 SHALL have port clear, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port IR, input, 32 bits: instruction register contents from the datapath, with opcode [31:27], Ra [26:23], Rb [22:19] and Rc [18:15].
REQ-004 SHALL have port MemReady, input, 1 bit: memory read-data-valid, sampled in T1.
REQ-005 SHALL have ports Rin and Rout, output, 16 bits each: one-hot general-register load and drive strobes (bit n = Rn).
REQ-006 SHALL have ports PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin and LOin, output, 1 bit each: datapath strobes.
REQ-007 SHALL have port opcode, output, 5 bits: ALU operation select.
REQ-008 SHALL have port Run, output, 1 bit: high unless halted.

Function
REQ-009 SHALL implement the states RST, T0, T1, T2, T3, T4, T5, T6 and HALT, with one state per clock.
REQ-010 Strobes SHALL be Moore outputs, asserted only in the states listed below and 0 in all others.
REQ-011 SHALL decode opcodes as: add=00011, sub=00100, and=00101, or=00110, mul=01111, div=10000, nop=11001, halt=11010; any other opcode SHALL be treated as nop.
REQ-012 RST SHALL go to T0 on the next clock when clear is low.
REQ-013 T0 SHALL assert PCout, MARin, IncPC and Zlowin, then go to T1.
REQ-014 T1 SHALL assert Zlowout, PCin, Read and MDRin, and go to T2 only when MemReady=1.
REQ-015 While MemReady=0 in T1, the sequencer SHALL remain in T1 with PCin deasserted and Read and MDRin held; PCin SHALL pulse only in the cycle MemReady=1.
REQ-016 T2 SHALL assert MDRout and IRin, then go to T3.
REQ-017 IR SHALL be decoded in T3 through T6 only and treated as stable during those states.
REQ-018 For ALU ops, T3 SHALL assert Rout[Rb] and Yin, then go to T4.
REQ-019 For ALU ops, T4 SHALL assert Rout[Rc] and Zlowin, and drive opcode=IR[31:27]; opcode SHALL be 00000 in every other state.
REQ-020 For mul and div, T4 SHALL also assert Zhighin.
REQ-021 For add, sub, and and or, T5 SHALL assert Zlowout and Rin[Ra], then go to T0.
REQ-022 For mul and div, T5 SHALL assert Zlowout and LOin and go to T6; T6 SHALL assert Zhighout and HIin and go to T0.
REQ-023 For nop, T3 SHALL assert no strobes and go to T0.
REQ-024 For halt, T3 SHALL go to HALT.
REQ-025 HALT SHALL hold all strobes at 0 and Run=0, and SHALL exit only via clear.
REQ-026 At most one bit of Rout and at most one bit of Rin SHALL be set in any cycle.
REQ-027 Ra=Rb=Rc (e.g. add R2,R2,R2) SHALL be sequenced normally with no special case.
REQ-028 A full ALU instruction SHALL take 6 cycles, mul/div 7, nop 4 and halt 4, each assuming MemReady=1 in the first T1 cycle.

Reset
REQ-029 clear=1 at a rising edge SHALL force RST from any state, including mid-instruction, T1 stalls and HALT.
REQ-030 Strobes asserted in the aborted state SHALL drop in the cycle after that edge.
REQ-031 In RST, every output except Run SHALL be 0, and Run SHALL be 1.
REQ-032 clear SHALL take priority over MemReady and over all state transitions.

Configuration
REQ-033 Macro CU_MULDIV_EN SHALL control multiply/divide sequencing.
REQ-034 With CU_MULDIV_EN defined, mul and div SHALL follow REQ-020 and REQ-022.
REQ-035 Without CU_MULDIV_EN, opcodes 01111 and 10000 SHALL decode as nop, state T6 SHALL be unreachable, and Zhighin, Zhighout, HIin and LOin SHALL be tied to 0.

Verification
REQ-036 Scenario: clear high 2 cycles, then low, MemReady=1, IR=32'h18918000 (add R1,R2,R3) -> T0..T5 in 6 cycles; T3 Rout=16'h0004, Yin=1; T4 Rout=16'h0008, opcode=00011, Zlowin=1; T5 Rin=16'h0002, Zlowout=1.
REQ-037 Scenario: MemReady held 0 for 3 cycles in T1 -> state stays T1 for 4 cycles, Read=1 throughout, PCin=1 only in the 4th cycle.
REQ-038 Scenario: IR=32'h7A218000 (mul R4,R4,R3) with CU_MULDIV_EN -> T4 Zlowin=Zhighin=1, opcode=01111; T5 LOin=1; T6 HIin=1; next state T0. Without the macro -> T3 then T0, no strobes in T3.
REQ-039 Scenario: IR opcode 11010 -> HALT entered after T3, Run=0 and all strobes 0 for 10 cycles; clear=1 -> RST, then T0.
REQ-040 Scenario: clear asserted during T4 of add -> next cycle RST with Rout=0, Zlowin=0 and opcode=0; fetch restarts at T0.
REQ-041 Scenario: IR opcode 11111 (undefined) -> treated as nop, T3 then T0, Rin=Rout=0 throughout.

Source files
------------

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Hardwired control unit for a simple bus-based datapath. Steps through
// fetch (T0..T2) and execute (T3..T6) one state per clock and drives Moore
// datapath strobes from the current state and the decoded instruction.
//
// Ports
//   Clock      : system clock, all state changes on the rising edge
//   clear      : synchronous active-high reset, forces RST from any state
//   IR[31:0]   : instruction register, opcode [31:27], Ra [26:23],
//                Rb [22:19], Rc [18:15]; only looked at in T3..T6
//   MemReady   : memory read data valid, sampled in T1
//   Rin/Rout   : one-hot general register load / drive strobes (bit n = Rn)
//   PCout .. LOin : single-bit datapath strobes
//   opcode     : ALU operation select, nonzero only in T4 of an ALU op
//   Run        : 1 unless the sequencer is halted
//
// Build option
//   CU_MULDIV_EN : when defined, mul/div run a 7-cycle sequence that writes
//                  HI/LO through T6. When undefined, mul/div decode as nop,
//                  T6 is never entered and Zhighin/Zhighout/HIin/LOin are 0.
// -----------------------------------------------------------------------------
module control_sequencer (
    input  logic        Clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        MemReady,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        IRin,
    output logic        Yin,
    output logic        Zlowin,
    output logic        Zhighin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic [4:0]  opcode,
    output logic        Run
);

    typedef enum logic [3:0] {
        ST_RST,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALT
    } state_e;

    // nop (11001) and every undefined opcode share the default decode path,
    // so only the opcodes that change sequencing are named here.
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_HALT = 5'b11010;
`ifdef CU_MULDIV_EN
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
`endif

    state_e state_q;
    state_e state_d;

    logic [4:0]  ir_op;
    logic        op_alu2;     // add/sub/and/or: result to Rin[Ra] in T5
    logic        op_muldiv;   // mul/div: result to LO/HI in T5/T6
    logic        op_halt;
    logic [15:0] ra_onehot;
    logic [15:0] rb_onehot;
    logic [15:0] rc_onehot;

    // Low IR bits carry immediates for other units; not used for sequencing.
    logic        unused_ir_bits;
    assign unused_ir_bits = ^IR[14:0];

    // -------------------------------------------------------------------------
    // Instruction decode
    // -------------------------------------------------------------------------
    always_comb begin
        ir_op     = IR[31:27];
        op_alu2   = (ir_op == OP_ADD) || (ir_op == OP_SUB) ||
                    (ir_op == OP_AND) || (ir_op == OP_OR);
`ifdef CU_MULDIV_EN
        op_muldiv = (ir_op == OP_MUL) || (ir_op == OP_DIV);
`else
        op_muldiv = 1'b0;
`endif
        op_halt   = (ir_op == OP_HALT);
        ra_onehot = 16'h0001 << IR[26:23];
        rb_onehot = 16'h0001 << IR[22:19];
        rc_onehot = 16'h0001 << IR[18:15];
    end

    // -------------------------------------------------------------------------
    // State register; clear wins over every transition including T1 stalls.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge Clock) begin
        if (clear) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST:  state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1:   state_d = MemReady ? ST_T2 : ST_T1;
            ST_T2:   state_d = ST_T3;
            ST_T3: begin
                if (op_alu2 || op_muldiv) begin
                    state_d = ST_T4;
                end else if (op_halt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_T0;
                end
            end
            ST_T4:   state_d = ST_T5;
            ST_T5:   state_d = op_muldiv ? ST_T6 : ST_T0;
            ST_T6:   state_d = ST_T0;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        Rin      = '0;
        Rout     = '0;
        PCout    = 1'b0;
        PCin     = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        Read     = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zlowin   = 1'b0;
        Zhighin  = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        opcode   = 5'b00000;
        Run      = 1'b1;
        case (state_q)
            ST_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                Zlowin = 1'b1;
            end
            ST_T1: begin
                Zlowout = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                // PC is loaded from Z once only, in the cycle that leaves T1;
                // during a stall the read is held without re-writing PC.
                PCin    = MemReady;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                if (op_alu2 || op_muldiv) begin
                    Rout = rb_onehot;
                    Yin  = 1'b1;
                end
            end
            ST_T4: begin
                Rout    = rc_onehot;
                Zlowin  = 1'b1;
                opcode  = ir_op;
`ifdef CU_MULDIV_EN
                Zhighin = op_muldiv;
`endif
            end
            ST_T5: begin
                Zlowout = 1'b1;
`ifdef CU_MULDIV_EN
                if (op_muldiv) begin
                    LOin = 1'b1;
                end else begin
                    Rin  = ra_onehot;
                end
`else
                Rin = ra_onehot;
`endif
            end
            ST_T6: begin
`ifdef CU_MULDIV_EN
                Zhighout = 1'b1;
                HIin     = 1'b1;
`endif
            end
            ST_HALT: begin
                Run = 1'b0;
            end
            default: begin
            end
        endcase
    end

endmodule
